// File: rtl/mf_readout_pkg.sv
// Shared types and helpers for the mixer accumulator readout sequencer.
// Index widths cover up to 16 frequencies and 16 channels.
package mf_readout_pkg;

  localparam int IDX_W    = 4;
  localparam int MAX_FREQ = 16;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    SETTLE,
    STREAM,
    FIN
  } state_e;

  // Lowest set bit strictly above idx; MSB of the result flags "none left".
  function automatic logic [IDX_W:0] next_set_bit(input logic [MAX_FREQ-1:0] mask,
                                                  input logic [IDX_W-1:0]    idx);
    logic [IDX_W:0] r;
    r = {1'b1, {IDX_W{1'b0}}};
    for (int i = MAX_FREQ - 1; i >= 0; i--) begin
      if (i > int'(idx) && mask[i]) r = {1'b0, IDX_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/mf_word_sel.sv
// Combinational pick of one 32-bit I or Q accumulator word by (freq, chan).
// Zero latency; no flow control.
module mf_word_sel
  import mf_readout_pkg::*;
#(
  parameter int FREQ_NUM = 6,
  parameter int CHANNEL  = 8
) (
  input  logic [32*CHANNEL*FREQ_NUM-1:0] ibus_i,
  input  logic [32*CHANNEL*FREQ_NUM-1:0] qbus_i,
  input  logic [IDX_W-1:0]               freq_i,
  input  logic [IDX_W-1:0]               chan_i,
  input  logic                           q_i,
  output logic [31:0]                    word_o
);

  localparam int WORDS = FREQ_NUM * CHANNEL;

  int idx;

  always_comb begin
    idx    = int'(freq_i) * CHANNEL + int'(chan_i);
    word_o = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == k) word_o = q_i ? qbus_i[32*k +: 32] : ibus_i[32*k +: 32];
    end
  end

endmodule

// File: rtl/mf_acc_readout.sv
// Snapshot strobe then I/Q word stream of enabled frequencies; first word 3 cycles after start.
// Valid/ready output, registered valid/tags; words held stable while stalled.
module mf_acc_readout
  import mf_readout_pkg::*;
#(
  parameter int FREQ_NUM = 6,
  parameter int CHANNEL  = 8
) (
  input  logic                           clk_2,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [FREQ_NUM-1:0]            freq_mask,
  output logic                           mf_iq_read,
  input  logic [32*CHANNEL*FREQ_NUM-1:0] mf_ipcm_acc_in,
  input  logic [32*CHANNEL*FREQ_NUM-1:0] mf_qpcm_acc_in,
  output logic [31:0]                    out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [3:0]                     out_freq,
  output logic [3:0]                     out_chan,
  output logic                           out_q,
  output logic                           busy,
  output logic                           done,
  input  logic                           err_clr,
  output logic                           err
);

  localparam logic [IDX_W-1:0] CHAN_MAX = IDX_W'(CHANNEL - 1);

  state_e              state_q;
  logic [FREQ_NUM-1:0] mask_q;
  logic [IDX_W-1:0]    f_q, c_q;
  logic                q_q;
  logic                valid_q, last_q, busy_q, done_q, read_q, err_q;

  logic [IDX_W:0]      nsb_in, nsb_cur, nsb_nxt;
  logic [IDX_W-1:0]    first_f, f_d, c_d;
  logic                q_d, last_d, err_d, hs;
  logic [31:0]         word;

  // Walk order is q, then channel, then the next enabled frequency.
  always_comb begin
    nsb_in  = next_set_bit(MAX_FREQ'(freq_mask), '0);
    first_f = freq_mask[0] ? '0 : nsb_in[IDX_W-1:0];
    nsb_cur = next_set_bit(MAX_FREQ'(mask_q), f_q);
    f_d     = f_q;
    c_d     = c_q;
    q_d     = ~q_q;
    if (q_q) begin
      if (c_q == CHAN_MAX) begin
        c_d = '0;
        f_d = nsb_cur[IDX_W-1:0];
      end else begin
        c_d = c_q + 1'b1;
      end
    end
    nsb_nxt = next_set_bit(MAX_FREQ'(mask_q), f_d);
    last_d  = q_d && (c_d == CHAN_MAX) && nsb_nxt[IDX_W];
    hs      = valid_q && out_ready;
    err_d   = err_clr ? 1'b0 : ((start && state_q != IDLE) ? 1'b1 : err_q);
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      f_q     <= '0;
      c_q     <= '0;
      q_q     <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q  <= err_d;
      read_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (|freq_mask) begin
              mask_q  <= freq_mask;
              f_q     <= first_f;
              c_q     <= '0;
              q_q     <= 1'b0;
              read_q  <= 1'b1;
              state_q <= SNAP;
            end else begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        SNAP:   state_q <= SETTLE;
        SETTLE: begin
          valid_q <= 1'b1;
          last_q  <= 1'b0;
          state_q <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              f_q     <= '0;
              c_q     <= '0;
              q_q     <= 1'b0;
              state_q <= FIN;
            end else begin
              f_q    <= f_d;
              c_q    <= c_d;
              q_q    <= q_d;
              last_q <= last_d;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mf_word_sel #(
    .FREQ_NUM(FREQ_NUM),
    .CHANNEL (CHANNEL)
  ) u_word_sel (
    .ibus_i(mf_ipcm_acc_in),
    .qbus_i(mf_qpcm_acc_in),
    .freq_i(f_q),
    .chan_i(c_q),
    .q_i   (q_q),
    .word_o(word)
  );

  assign out_data   = valid_q ? word : '0;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign out_freq   = f_q;
  assign out_chan   = c_q;
  assign out_q      = q_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mf_iq_read = read_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mf_acc_readout.sv
// Directed bench for mf_acc_readout: ordering, timing, backpressure, errors, reset abort.
module tb_mf_acc_readout;

  localparam int FN = 6;
  localparam int CH = 8;

  logic                  clk_2 = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [FN-1:0]         freq_mask;
  logic                  mf_iq_read;
  logic [32*CH*FN-1:0]   ibus, qbus;
  logic [31:0]           out_data;
  logic                  out_valid, out_ready, out_last, out_q;
  logic [3:0]            out_freq, out_chan;
  logic                  busy, done, err_clr, err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_2 = ~clk_2;

  mf_acc_readout #(.FREQ_NUM(FN), .CHANNEL(CH)) dut (
    .clk_2         (clk_2),
    .rst_n         (rst_n),
    .start         (start),
    .freq_mask     (freq_mask),
    .mf_iq_read    (mf_iq_read),
    .mf_ipcm_acc_in(ibus),
    .mf_qpcm_acc_in(qbus),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .out_freq      (out_freq),
    .out_chan      (out_chan),
    .out_q         (out_q),
    .busy          (busy),
    .done          (done),
    .err_clr       (err_clr),
    .err           (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_word(input int f, input int c, input int q);
    return {(q != 0) ? 16'hBEEF : 16'hCAFE, 4'(f), 4'(c), 8'(f * 8 + c)};
  endfunction

  function automatic logic [9:0] tags();
    return {out_freq, out_chan, out_q, out_last};
  endfunction

  // bp: random ready; inject: start/err_clr pokes mid-dump; abort_at >= 0: reset at that beat.
  task automatic run_dump(input logic [FN-1:0] mask, input bit bp, input bit inject,
                          input int abort_at);
    logic [31:0] ew[$];
    logic [9:0]  et[$];
    logic [31:0] hd;
    logic [9:0]  ht;
    int beat = 0, rel = 0, first_v = -1, done_rel = -1, nread = 0, ndone = 0, nvalid = 0;
    bit stall = 0, fin = 0, aborted = 0;

    for (int f = 0; f < FN; f++)
      if (mask[f])
        for (int c = 0; c < CH; c++)
          for (int q = 0; q < 2; q++) begin
            ew.push_back(exp_word(f, c, q));
            et.push_back({4'(f), 4'(c), 1'(q), 1'b0});
          end
    if (et.size() > 0) et[et.size()-1][0] = 1'b1;

    @(negedge clk_2);
    start     = 1'b1;
    freq_mask = mask;
    out_ready = 1'b1;

    while (!fin && rel < 3000) begin
      @(negedge clk_2);
      rel++;
      start     = 1'b0;
      err_clr   = 1'b0;
      freq_mask = ~mask;
      if (rel == 1) chk("busy_t1", busy, 1);
      if (mf_iq_read) begin
        nread++;
        chk("iq_read_cycle", rel, 1);
      end
      if (done) begin
        ndone++;
        done_rel = rel;
        chk("busy_with_done", busy, 1);
      end
      if (done_rel >= 0 && rel == done_rel + 1) begin
        chk("busy_after_done", busy, 0);
        fin = 1;
      end
      if (out_valid) begin
        nvalid++;
        if (first_v < 0) first_v = rel;
      end
      if (stall) begin
        chk("stall_data", out_data, hd);
        chk("stall_tags", 32'(tags()), 32'(ht));
      end
      if (abort_at >= 0 && beat == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", out_data, 0);
        chk("abort_tags", 32'(tags()), 0);
        repeat (2) @(negedge clk_2);
        rst_n = 1'b1;
        repeat (4) begin
          @(negedge clk_2);
          chk("abort_no_done", done, 0);
          chk("abort_idle_valid", out_valid, 0);
        end
        chk("abort_err", err, 0);
        aborted = 1;
        fin     = 1;
      end else begin
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        stall     = out_valid && !out_ready;
        hd        = out_data;
        ht        = tags();
        if (inject) begin
          if (beat == 20) chk("err_after_start", err, 1);
          if (beat == 27) chk("err_clear_wins", err, 0);
          if (beat == 32) chk("err_set_again", err, 1);
          if (beat == 37) chk("err_cleared", err, 0);
          if (beat == 10 || beat == 30) start = 1'b1;
          if (beat == 25) begin start = 1'b1; err_clr = 1'b1; end
          if (beat == 35) err_clr = 1'b1;
        end
        if (out_valid && out_ready) begin
          if (beat < ew.size()) begin
            chk($sformatf("data[%0d]", beat), out_data, ew[beat]);
            chk($sformatf("tags[%0d]", beat), 32'(tags()), 32'(et[beat]));
          end else begin
            chk("extra_beat", beat, ew.size());
          end
          beat++;
        end
      end
    end

    if (!fin) chk("timeout", 0, 1);
    if (!aborted) begin
      chk("beat_count", beat, ew.size());
      chk("iq_read_count", nread, (mask != 0) ? 1 : 0);
      chk("done_count", ndone, 1);
      if (mask != 0) chk("first_valid_rel", first_v, 3);
      else           chk("zero_mask_valid", nvalid, 0);
      if (!bp) chk("done_rel", done_rel, (mask != 0) ? 3 + ew.size() : 1);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    freq_mask = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    for (int f = 0; f < FN; f++)
      for (int c = 0; c < CH; c++) begin
        ibus[32*(f*CH+c) +: 32] = exp_word(f, c, 0);
        qbus[32*(f*CH+c) +: 32] = exp_word(f, c, 1);
      end
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_iq_read", mf_iq_read, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_tags", 32'(tags()), 0);
    @(negedge clk_2);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_2);

    run_dump(6'b111111, 1'b0, 1'b0, -1);
    run_dump(6'b100101, 1'b0, 1'b0, -1);
    run_dump(6'b111111, 1'b1, 1'b0, -1);
    run_dump(6'b100101, 1'b1, 1'b0, -1);
    run_dump(6'b000000, 1'b0, 1'b0, -1);
    run_dump(6'b111111, 1'b0, 1'b1, -1);
    run_dump(6'b111111, 1'b0, 1'b0, 20);
    run_dump(6'b111111, 1'b0, 1'b0, -1);
    run_dump(6'b010000, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
